// File: rtl/instruction_encoder.sv
// Packs opcode/register/immediate tuples into 32-bit instruction words and streams
// them through a 2-entry FIFO into instruction memory starting at address 0.
module instruction_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        opcode,
    input  logic [4:0]        reg1,
    input  logic [4:0]        reg2,
    input  logic [4:0]        reg3,
    input  logic [4:0]        sr_amount,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_imm,
    output logic              err_ovf
);

    localparam int CAP = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CAP_V  = (ADDR_W + 1)'(CAP);
    localparam logic [ADDR_W:0] LAST_V = (ADDR_W + 1)'(CAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [31:0]       fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   acc_q;
    logic              done_q;
    logic              err_imm_q;
    logic              err_ovf_q;

    logic              accept;
    logic              retire;
    logic              is_itype;
    logic              imm_fits;
    logic              last_slot;
    logic [31:0]       word;

    assign is_itype  = opcode[4];
    assign imm_fits  = (&imm[31:15]) | (~|imm[31:15]);
    assign last_slot = (acc_q == LAST_V);
    assign word      = is_itype ? {opcode, reg1, reg2, imm[15:0]}
                                : {opcode, reg1, reg2, reg3, sr_amount, 6'b000000};

    // Readiness depends only on registered state, so a full FIFO never passes a word through.
    assign in_ready  = (state_q == LOAD) && !count_q[1] && (acc_q < CAP_V) && !start;
    assign accept    = in_valid && in_ready;
    assign retire    = mem_we && mem_ready;

    always_comb begin
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            err_imm_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else if (start) begin
            state_q   <= LOAD;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            err_imm_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                fifo_q[wr_ptr_q] <= word;
                wr_ptr_q         <= ~wr_ptr_q;
                acc_q            <= acc_q + 1'b1;
                if (is_itype && !imm_fits) begin
                    err_imm_q <= 1'b1;
                end
                if (last_slot && !in_last) begin
                    err_ovf_q <= 1'b1;
                end
            end
            if (retire) begin
                rd_ptr_q <= ~rd_ptr_q;
                addr_q   <= addr_q + 1'b1;
            end
            case (state_q)
                LOAD: begin
                    if (accept && (in_last || last_slot)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_q == 2'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we    = (count_q != 2'd0);
    assign mem_wdata = fifo_q[rd_ptr_q];
    assign mem_addr  = addr_q;
    assign done      = done_q;
    assign err_imm   = err_imm_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Drives a default-size and a 4-word encoder with identical stimulus and compares both
// against a word-list model of the expected write stream.
module tb_instruction_encoder;

    localparam int NI = 2;
    localparam int S_IDLE = 0, S_LOAD = 1, S_DRAIN = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last, mem_ready;
    logic [5:0]  opcode;
    logic [4:0]  reg1, reg2, reg3, sr_amount;
    logic [31:0] imm;

    logic [1:0]  in_ready_v, mem_we_v, done_v, err_imm_v, err_ovf_v;
    logic [31:0] wdata0, wdata1;
    logic [7:0]  addr0;
    logic [1:0]  addr1;

    int          checks = 0;
    int          errors = 0;

    int          m_state [NI];
    int          m_acc   [NI];
    int          m_ret   [NI];
    bit          m_eimm  [NI];
    bit          m_eovf  [NI];
    logic [31:0] m_words [NI][256];
    int          cap     [NI] = '{256, 4};

    always #5 clk = ~clk;

    instruction_encoder u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .in_last(in_last), .opcode(opcode),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .sr_amount(sr_amount), .imm(imm),
        .mem_we(mem_we_v[0]), .mem_ready(mem_ready), .mem_addr(addr0),
        .mem_wdata(wdata0), .done(done_v[0]), .err_imm(err_imm_v[0]), .err_ovf(err_ovf_v[0])
    );

    instruction_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .in_last(in_last), .opcode(opcode),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .sr_amount(sr_amount), .imm(imm),
        .mem_we(mem_we_v[1]), .mem_ready(mem_ready), .mem_addr(addr1),
        .mem_wdata(wdata1), .done(done_v[1]), .err_imm(err_imm_v[1]), .err_ovf(err_ovf_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] c,
                                           input logic [4:0] s, input logic [31:0] im);
        int unsigned w;
        w = int'(op) * (2 ** 26) + int'(a) * (2 ** 21) + int'(b) * (2 ** 16);
        if (op[4]) w = w + (im % 32'd65536);
        else       w = w + int'(c) * (2 ** 11) + int'(s) * (2 ** 6);
        return w;
    endfunction

    function automatic bit fits16(input logic [31:0] v);
        return ($signed(v) >= -32768) && ($signed(v) <= 32767);
    endfunction

    function automatic logic [31:0] obs_addr(input int i);
        return (i == 0) ? {24'b0, addr0} : {30'b0, addr1};
    endfunction

    function automatic logic [31:0] obs_wdata(input int i);
        return (i == 0) ? wdata0 : wdata1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_state[i] = S_IDLE;
            m_acc[i]   = 0;
            m_ret[i]   = 0;
            m_eimm[i]  = 0;
            m_eovf[i]  = 0;
        end
    endtask

    // Compare outputs against the model, advance the model across the coming edge, wait one cycle.
    task automatic tick(output bit acc0);
        bit rdy [NI];
        #1;
        for (int i = 0; i < NI; i++) begin
            int pend = m_acc[i] - m_ret[i];
            rdy[i] = (m_state[i] == S_LOAD) && (pend < 2) && (m_acc[i] < cap[i]) && !start;
            chk($sformatf("in_ready[%0d]", i), {31'b0, in_ready_v[i]}, {31'b0, rdy[i]});
            chk($sformatf("mem_we[%0d]", i), {31'b0, mem_we_v[i]}, (pend != 0) ? 32'd1 : 32'd0);
            chk($sformatf("mem_addr[%0d]", i), obs_addr(i), m_ret[i] % cap[i]);
            if (pend != 0)
                chk($sformatf("mem_wdata[%0d]", i), obs_wdata(i), m_words[i][m_ret[i] % 256]);
            chk($sformatf("done[%0d]", i), {31'b0, done_v[i]}, (m_state[i] == S_DONE) ? 32'd1 : 32'd0);
            chk($sformatf("err_imm[%0d]", i), {31'b0, err_imm_v[i]}, {31'b0, m_eimm[i]});
            chk($sformatf("err_ovf[%0d]", i), {31'b0, err_ovf_v[i]}, {31'b0, m_eovf[i]});
        end
        acc0 = 0;
        for (int i = 0; i < NI; i++) begin
            int  sz  = m_acc[i] - m_ret[i];
            bit  acc = in_valid && rdy[i];
            bit  wr  = (sz != 0) && mem_ready;
            if (i == 0) acc0 = acc;
            if (start) begin
                m_state[i] = S_LOAD;
                m_acc[i]   = 0;
                m_ret[i]   = 0;
                m_eimm[i]  = 0;
                m_eovf[i]  = 0;
            end else begin
                if (wr) m_ret[i]++;
                if (acc) begin
                    m_words[i][m_acc[i] % 256] = encode(opcode, reg1, reg2, reg3, sr_amount, imm);
                    if (opcode[4] && !fits16(imm)) m_eimm[i] = 1;
                    m_acc[i]++;
                    if (m_acc[i] == cap[i] && !in_last) m_eovf[i] = 1;
                    if (in_last || m_acc[i] == cap[i]) m_state[i] = S_DRAIN;
                end else if (m_state[i] == S_DRAIN && sz == 0) begin
                    m_state[i] = S_DONE;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_in_ready[%0d]", i), {31'b0, in_ready_v[i]}, 32'd0);
            chk($sformatf("rst_mem_we[%0d]", i), {31'b0, mem_we_v[i]}, 32'd0);
            chk($sformatf("rst_mem_addr[%0d]", i), obs_addr(i), 32'd0);
            chk($sformatf("rst_mem_wdata[%0d]", i), obs_wdata(i), 32'd0);
            chk($sformatf("rst_flags[%0d]", i), {29'b0, done_v[i], err_imm_v[i], err_ovf_v[i]}, 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_tuple(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] s, input logic [31:0] im);
        opcode = op; reg1 = a; reg2 = b; reg3 = c; sr_amount = s; imm = im;
    endtask

    task automatic rand_tuple();
        logic [31:0] im;
        int          sel;
        logic [31:0] edges [4];
        edges = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF};
        sel = $urandom_range(0, 2);
        if (sel == 0)      im = 32'($urandom_range(0, 65535)) - 32'd32768;
        else if (sel == 1) im = $urandom;
        else               im = edges[$urandom_range(0, 3)];
        set_tuple(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im);
    endtask

    task automatic run_program(input int n, input int v_pct, input int r_pct, input int stall);
        int idx = 0;
        int cyc = 0;
        bit a;
        start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        tick(a);
        start = 1'b0;
        rand_tuple();
        while ((idx < n || m_state[0] != S_DONE) && cyc < 400) begin
            in_valid  = (idx < n) && ($urandom_range(1, 100) <= v_pct);
            in_last   = (idx == n - 1);
            mem_ready = (cyc >= stall) && ($urandom_range(1, 100) <= r_pct);
            if (stall >= 3 && cyc == stall)
                chk("fifo_full_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
            tick(a);
            if (a) begin
                idx++;
                rand_tuple();
            end
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("program_in_time", (cyc < 400) ? 32'd1 : 32'd0, 32'd1);
        chk("program_done", {31'b0, done_v[0]}, 32'd1);
    endtask

    initial begin
        bit a;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
        set_tuple(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        model_reset();
        @(negedge clk);
        apply_reset();
        tick(a);
        tick(a);

        // R-type word, one-cycle write latency, done two cycles after the write appears
        start = 1'b1; tick(a); start = 1'b0;
        set_tuple(6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 32'd0);
        in_valid = 1'b1; in_last = 1'b1; mem_ready = 1'b1;
        tick(a);
        in_valid = 1'b0; in_last = 1'b0;
        chk("rtype_accepted", {31'b0, a}, 32'd1);
        chk("rtype_we", {31'b0, mem_we_v[0]}, 32'd1);
        chk("rtype_addr", {24'b0, addr0}, 32'd0);
        chk("rtype_word", wdata0, 32'h0022_1900);
        tick(a);
        tick(a);
        chk("rtype_done", {31'b0, done_v[0]}, 32'd1);

        // I-type with an immediate that sign-extends cleanly
        start = 1'b1; tick(a); start = 1'b0;
        set_tuple(6'b010000, 5'd5, 5'd6, 5'd0, 5'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1; in_last = 1'b1;
        tick(a);
        in_valid = 1'b0; in_last = 1'b0;
        chk("itype_word", wdata0, 32'h40A6_FFFF);
        chk("itype_err_imm", {31'b0, err_imm_v[0]}, 32'd0);
        tick(a); tick(a); tick(a);

        // I-type immediate overflow: truncated word, sticky error until the next start
        start = 1'b1; tick(a); start = 1'b0;
        set_tuple(6'b010000, 5'd5, 5'd6, 5'd0, 5'd0, 32'h0001_0000);
        in_valid = 1'b1; in_last = 1'b1;
        tick(a);
        in_valid = 1'b0; in_last = 1'b0;
        chk("imm_ovf_low16", wdata0 & 32'h0000_FFFF, 32'd0);
        chk("imm_ovf_err", {31'b0, err_imm_v[0]}, 32'd1);
        tick(a); tick(a); tick(a); tick(a);
        chk("imm_ovf_sticky", {31'b0, err_imm_v[0]}, 32'd1);
        start = 1'b1; tick(a); start = 1'b0;
        chk("imm_err_cleared", {31'b0, err_imm_v[0]}, 32'd0);
        tick(a);

        // Memory stalled: FIFO fills after two accepts, then drains in order
        run_program(3, 100, 100, 4);

        // Five tuples without in_last: the 4-word encoder overflows and finishes on its own
        run_program(5, 100, 100, 0);
        chk("ovf_small_err", {31'b0, err_ovf_v[1]}, 32'd1);
        chk("ovf_small_done", {31'b0, done_v[1]}, 32'd1);
        chk("ovf_big_clean", {31'b0, err_ovf_v[0]}, 32'd0);

        // Reset with two words pending discards them
        start = 1'b1; tick(a); start = 1'b0;
        mem_ready = 1'b0; in_valid = 1'b1;
        rand_tuple(); tick(a);
        rand_tuple(); tick(a);
        in_valid = 1'b0;
        chk("pre_reset_we", {31'b0, mem_we_v[0]}, 32'd1);
        apply_reset();
        mem_ready = 1'b1; in_valid = 1'b1;
        tick(a); tick(a); tick(a);
        in_valid = 1'b0;
        chk("post_reset_no_we", {31'b0, mem_we_v[0]}, 32'd0);

        for (int k = 0; k < 15; k++)
            run_program($urandom_range(1, 7), $urandom_range(40, 100), $urandom_range(30, 100), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory address width; capacity CAP = 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a new program load at address 0.
REQ-005 in_valid  input  1  field tuple present.
REQ-006 in_ready  output  1  encoder accepts tuple this cycle.
REQ-007 in_last  input  1  qualifies final tuple of the program.
REQ-008 opcode  input  6  instruction opcode.
REQ-009 reg1, reg2, reg3, sr_amount  input  5 each  register and shift-amount fields.
REQ-010 imm  input  32  signed immediate.
REQ-011 mem_we  output  1  write request to instruction memory.
REQ-012 mem_ready  input  1  memory accepts the write this cycle.
REQ-013 mem_addr  output  ADDR_W  word address of the current write.
REQ-014 mem_wdata  output  32  encoded instruction word.
REQ-015 done  output  1  load complete, all words written.
REQ-016 err_imm  output  1  sticky: an immediate did not fit in 16 signed bits.
REQ-017 err_ovf  output  1  sticky: CAP words accepted without in_last.

Function
REQ-018 Tuple accepted on a rising edge with in_valid && in_ready; write completes on a rising edge with mem_we && mem_ready.
REQ-019 I-type when opcode[4]=1: word = {opcode, reg1, reg2, imm[15:0]}; reg3 and sr_amount ignored.
REQ-020 R-type when opcode[4]=0: word = {opcode, reg1, reg2, reg3, sr_amount, 6'b000000}; imm ignored.
REQ-021 I-type with imm[31:15] not all equal: err_imm set on the accept edge; word still written with imm[15:0].
REQ-022 Encoded words enter a 2-entry FIFO on the accept edge; mem_we = FIFO non-empty; mem_wdata = FIFO head; latency is 1 cycle from accept edge to mem_we.
REQ-023 Writes retire in acceptance order; mem_addr starts at 0 after start and increments by 1 per completed write.
REQ-024 States: IDLE, LOAD, DRAIN, DONE.
REQ-025 IDLE -> LOAD on start; LOAD -> DRAIN on accepting the in_last tuple or the CAP-th tuple; DRAIN -> DONE when the FIFO is empty; DONE -> LOAD on start.
REQ-026 in_ready = (state==LOAD) && FIFO count < 2 && accepted count < CAP; no combinational path from mem_ready to in_ready.
REQ-027 FIFO full with a simultaneous write completion: in_ready stays 0 that cycle; no pass-through.
REQ-028 CAP-th tuple accepted with in_last=0: err_ovf set; all further tuples refused until start.
REQ-029 start in any state: FIFO flushed, mem_addr and accepted count cleared, err_imm, err_ovf and done cleared, state = LOAD on the next edge.
REQ-030 done = 1 only in DONE.
REQ-031 mem_addr wraps modulo CAP; it never exceeds CAP-1 because acceptance is capped at CAP.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err_imm=0, err_ovf=0.
REQ-033 Reset asserted mid-LOAD or mid-DRAIN discards pending words; no further mem_we until a start after reset release.

Verification
REQ-034 R-type: start; opcode=0, reg1=1, reg2=2, reg3=3, sr_amount=4, in_last=1, mem_ready=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221900; done=1 two cycles later.
REQ-035 I-type: opcode=6'b010000, reg1=5, reg2=6, imm=0xFFFFFFFF -> mem_wdata=0x40A6FFFF, err_imm=0.
REQ-036 I-type with imm=0x00010000 -> mem_wdata low 16 bits = 0x0000, err_imm=1, remains 1 until start.
REQ-037 mem_ready=0 with 3 tuples offered -> in_ready drops after 2 accepts; after mem_ready=1, writes occur at addresses 0, 1, 2 in order with correct data.
REQ-038 ADDR_W=2, 5 tuples offered with in_last=0 -> 4 writes at addresses 0..3, err_ovf=1, done=1, fifth tuple never accepted.
REQ-039 rst_n pulled low while 2 words are pending -> mem_we=0 immediately; no further writes after release without start.
